// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch, data
// load/store and a debug/loader port, with aging and a one-cycle read return.
module mips_mem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DW-1:0]    if_rdata,
  output logic             if_stall,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DW-1:0]    d_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [DW-1:0]    dbg_wdata,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [DW-1:0]    dbg_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_D, SRC_DBG} src_t;

  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

  src_t          sel;
  src_t          owner;
  src_t          owner_nxt;
  logic [3:0]    if_age;
  logic [3:0]    dbg_age;
  logic          if_prom;
  logic          dbg_prom;
  logic          multi_req;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  assign if_prom   = if_req && (if_age == AGE_MAX);
  assign dbg_prom  = dbg_req && (dbg_age == AGE_MAX);
  assign multi_req = (if_req && d_req) || (if_req && dbg_req) || (d_req && dbg_req);

  // A starved requester overrides the fixed D > IF > DBG order; IF wins a tie.
  always_comb begin
    sel = SRC_NONE;
    if (rst_n) begin
      if (if_prom)       sel = SRC_IF;
      else if (dbg_prom) sel = SRC_DBG;
      else if (d_req)    sel = SRC_D;
      else if (if_req)   sel = SRC_IF;
      else if (dbg_req)  sel = SRC_DBG;
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    dbg_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_nxt = SRC_NONE;
    case (sel)
      SRC_IF: begin
        if_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = if_addr;
        owner_nxt = SRC_IF;
      end
      SRC_D: begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        owner_nxt = d_we ? SRC_NONE : SRC_D;
      end
      SRC_DBG: begin
        dbg_gnt   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        owner_nxt = dbg_we ? SRC_NONE : SRC_DBG;
      end
      default: ;
    endcase
  end

  assign if_stall = if_req && !if_gnt;

  // Gating with rst_n drops the return of a read granted just before reset.
  assign if_rvalid  = rst_n && (owner == SRC_IF);
  assign d_rvalid   = rst_n && (owner == SRC_D);
  assign dbg_rvalid = rst_n && (owner == SRC_DBG);

  assign if_rdata  = if_rvalid  ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid   ? mem_rdata : d_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= SRC_NONE;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      dbg_rdata_q <= '0;
    end else begin
      owner <= owner_nxt;
      if (if_rvalid)  if_rdata_q  <= mem_rdata;
      if (d_rvalid)   d_rdata_q   <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_age       <= '0;
      dbg_age      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (if_req && !if_gnt)
        if_age <= (if_age == AGE_MAX) ? if_age : if_age + 4'd1;
      else
        if_age <= '0;
      if (dbg_req && !dbg_gnt)
        dbg_age <= (dbg_age == AGE_MAX) ? dbg_age : dbg_age + 4'd1;
      else
        dbg_age <= '0;
      if (multi_req && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: a request-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_mips_mem_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam int NONE = 0;
  localparam int SIF  = 1;
  localparam int SD   = 2;
  localparam int SDBG = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_req;
  logic [AW-1:0]    if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [DW-1:0]    if_rdata;
  logic             if_stall;
  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [DW-1:0]    d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [DW-1:0]    d_rdata;
  logic             dbg_req;
  logic             dbg_we;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_wdata;
  logic             dbg_gnt;
  logic             dbg_rvalid;
  logic [DW-1:0]    dbg_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Shared single-port memory driven only by the arbiter's memory bus.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int            checks = 0;
  int            errors = 0;
  bit            model_ok = 0;
  int            if_wait, dbg_wait, pend, cnt, pw, cw;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] hold [4];
  bit            known [4];
  logic [2:0]    gnt_log [$];
  logic [DW-1:0] prog [9];
  logic [2:0]    prio_exp [5];
  logic [2:0]    starve_exp [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick();
    if (!rst_n) return NONE;
    if (if_req && if_wait >= MAX_WAIT) return SIF;
    if (dbg_req && dbg_wait >= MAX_WAIT) return SDBG;
    if (d_req) return SD;
    if (if_req) return SIF;
    if (dbg_req) return SDBG;
    return NONE;
  endfunction

  function automatic logic [AW-1:0] bus_addr(input int w);
    case (w)
      SIF:     return if_addr;
      SD:      return d_addr;
      SDBG:    return dbg_addr;
      default: return '0;
    endcase
  endfunction

  function automatic logic bus_we(input int w);
    case (w)
      SD:      return d_we;
      SDBG:    return dbg_we;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] bus_wdata(input int w);
    case (w)
      SD:      return d_wdata;
      SDBG:    return dbg_wdata;
      default: return '0;
    endcase
  endfunction

  // Model state advances at each rising edge from the requests seen that cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      if_wait  = 0;
      dbg_wait = 0;
      pend     = NONE;
      cnt      = 0;
      for (int k = 0; k < 4; k++) known[k] = 0;
      model_ok = 1;
    end else if (model_ok) begin
      pw = pick();
      if (pend != NONE) begin
        hold[pend]  = pend_data;
        known[pend] = 1;
      end
      pend = NONE;
      if (pw != NONE) begin
        if (bus_we(pw)) model_mem[bus_addr(pw)] = bus_wdata(pw);
        else begin
          pend      = pw;
          pend_data = model_mem[bus_addr(pw)];
        end
      end
      if_wait  = (if_req && pw != SIF)   ? ((if_wait < MAX_WAIT) ? if_wait + 1 : if_wait) : 0;
      dbg_wait = (dbg_req && pw != SDBG) ? ((dbg_wait < MAX_WAIT) ? dbg_wait + 1 : dbg_wait) : 0;
      if ((int'(if_req) + int'(d_req) + int'(dbg_req)) >= 2 && cnt < CNT_MAX) cnt++;
    end
  end

  task automatic checkRdata(input string name, input int k, input logic [DW-1:0] act);
    if (rst_n && pend == k) checkOutput(name, 64'(act), 64'(pend_data));
    else if (known[k])      checkOutput(name, 64'(act), 64'(hold[k]));
  endtask

  always @(negedge clk) begin
    logic [43:0] exp_bus;
    if (model_ok) begin
      cw = pick();
      gnt_log.push_back({if_gnt, d_gnt, dbg_gnt});
      checkOutput("grant_stall", 64'({if_gnt, d_gnt, dbg_gnt, if_stall}),
                  64'({cw == SIF, cw == SD, cw == SDBG, if_req && cw != SIF}));
      exp_bus = (cw == NONE) ? 44'd0 : {1'b1, bus_we(cw), bus_addr(cw), bus_wdata(cw)};
      checkOutput("membus", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'(exp_bus));
      checkOutput("rvalid", 64'({if_rvalid, d_rvalid, dbg_rvalid}),
                  64'({rst_n && pend == SIF, rst_n && pend == SD, rst_n && pend == SDBG}));
      checkRdata("if_rdata", SIF, if_rdata);
      checkRdata("d_rdata", SD, d_rdata);
      checkRdata("dbg_rdata", SDBG, dbg_rdata);
      checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(cnt));
    end
  end

  task automatic applyStimulus(input int ir, input int ia, input int dr, input int dw,
                               input int da, input int dd, input int gr, input int gw,
                               input int ga, input int gd);
    if_req    = (ir != 0);
    if_addr   = AW'(ia);
    d_req     = (dr != 0);
    d_we      = (dw != 0);
    d_addr    = AW'(da);
    d_wdata   = DW'(dd);
    dbg_req   = (gr != 0);
    dbg_we    = (gw != 0);
    dbg_addr  = AW'(ga);
    dbg_wdata = DW'(gd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    gnt_log.delete();
  endtask

  initial begin
    int n;
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    prio_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    starve_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010, 3'b010,
                   3'b010, 3'b100, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 1024; i++) begin
      mem[i]       = '0;
      model_mem[i] = '0;
    end

    // Reset with every requester asserted.
    rst_n = 1'b0;
    applyStimulus(1, 0, 1, 0, 1, 0, 1, 0, 2, 0);
    repeat (3) step();
    @(negedge clk);
    checkOutput("rst_gnt", 64'({if_gnt, d_gnt, dbg_gnt}), 64'd0);
    checkOutput("rst_mem_en", 64'({mem_en, mem_we}), 64'd0);
    checkOutput("rst_cnt", 64'(conflict_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_gnt", 64'({if_gnt, d_gnt, dbg_gnt}), 64'(3'b010));
    step();

    // Loader path: program image then a read-back.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, i, int'(prog[i]));
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("ldr_rvalid", 64'(dbg_rvalid), 64'd1);
    checkOutput("ldr_rdata", 64'(dbg_rdata), 64'h00222000);
    n = 0;
    for (int i = 0; i < 9; i++) if (gnt_log[i] == 3'b001) n++;
    checkOutput("ldr_gnt_count", 64'(n), 64'd9);
    step();

    // IF starved by D until promotion.
    doReset();
    applyStimulus(1, 3, 1, 0, 3, 0, 0, 0, 0, 0);
    repeat (5) step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("prio_gnt%0d", i), 64'(gnt_log[i]), 64'(prio_exp[i]));
    checkOutput("prio_if_rvalid", 64'(if_rvalid), 64'd1);
    checkOutput("prio_if_rdata", 64'(if_rdata), 64'h0ce77800);
    checkOutput("prio_cnt", 64'(conflict_cnt), 64'd5);
    step();

    // All three contend: both low-priority ports get promoted in turn.
    doReset();
    applyStimulus(1, 0, 1, 0, 1, 0, 1, 0, 2, 0);
    repeat (16) step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("starve_gnt%0d", i), 64'(gnt_log[i]), 64'(starve_exp[i]));
    step();

    // Write then read of the same word on consecutive cycles.
    doReset();
    applyStimulus(0, 0, 1, 1, 20, 32'h0000abcd, 0, 0, 0, 0);
    step();
    applyStimulus(1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wtr_if_rvalid", 64'(if_rvalid), 64'd1);
    checkOutput("wtr_if_rdata", 64'(if_rdata), 64'h0000abcd);
    step();

    // Reset right after a granted read swallows the return.
    applyStimulus(1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("midrst_if_rvalid", 64'(if_rvalid), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_after_rvalid", 64'({if_rvalid, d_rvalid, dbg_rvalid}), 64'd0);
    step();

    // Long contention drives the counter into saturation.
    applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
    repeat (65540) step();
    @(negedge clk);
    checkOutput("sat_cnt", 64'(conflict_cnt), 64'hffff);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
